// File: rtl/pc_seq_unit.sv
// IF-stage program counter: sequential step, hazard stall, prioritised branch/jump
// redirect with a fetch-bubble window, and a start/idle FSM. Optional PC_MISALIGN_EN.
module pc_seq_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                STEP       = 4,
  parameter int                BUBBLE_CYC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hd_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jmp_i,
  input  logic [ADDR_W-1:0] jmp_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              pc_valid_o,
  output logic              redirect_o,
  output logic [1:0]        state_o
`ifdef PC_MISALIGN_EN
  ,
  output logic              misalign_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
  localparam logic [1:0]        BUB_INIT = 2'(BUBBLE_CYC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target;
  logic [1:0]        cnt_q, cnt_d;
  logic              redir_q, redir_d;
  logic              redir_req;
  logic              hold;

`ifdef PC_MISALIGN_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  logic mis_q, mis_d;

  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  // A misaligned PC behaves like a permanent stall until the next redirect.
  assign hold = mis_q;
`else
  assign hold = 1'b0;
`endif

  // Branch resolves in EX, so it is older than a jump decoded in ID and wins.
  assign redir_req = br_taken_i | jmp_i;
  assign target    = br_taken_i ? br_target_i : jmp_target_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    redir_d = 1'b0;
`ifdef PC_MISALIGN_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN, BUBBLE: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (redir_req) begin
          pc_d    = target;
          redir_d = 1'b1;
`ifdef PC_MISALIGN_EN
          mis_d   = misaligned(target);
`endif
          if (BUBBLE_CYC > 0) begin
            state_d = BUBBLE;
            cnt_d   = BUB_INIT;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == BUBBLE) begin
          if (cnt_q <= 2'd1) state_d = RUN;
          else               cnt_d   = cnt_q - 2'd1;
        end else if (!hd_i && !hold) begin
          pc_d = pc_q + STEP_V;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      cnt_q   <= 2'd0;
      redir_q <= 1'b0;
`ifdef PC_MISALIGN_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
`ifdef PC_MISALIGN_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign pc_o       = pc_q;
  assign pc_next_o  = pc_q + STEP_V;
  assign pc_valid_o = (state_q == RUN) && !hold;
  assign redirect_o = redir_q;
  assign state_o    = state_q;
`ifdef PC_MISALIGN_EN
  assign misalign_o = mis_q;
`endif

endmodule
